// File: rtl/sram1rw32x50_ctrl_pkg.sv
// Shared definitions for the 32x50 single-port SRAM controller.
//   - default geometry of the macro (depth, address width, word width)
//   - controller state encoding
package sram1rw32x50_ctrl_pkg;

  localparam int SRAM_DEPTH  = 32;
  localparam int SRAM_ADDR_W = 5;
  localparam int SRAM_DATA_W = 50;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sram1rw32x50_ctrl_rsp_fifo.sv
// sram_rsp_fifo: first-word-fall-through response FIFO for read data.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   push, push_data   write side; push accepted when not full, or when full
//                     and a pop happens in the same cycle
//   pop               read side; ignored while out_valid is low
//   out_valid         head entry present
//   out_data          head entry (valid whenever out_valid is high)
//   count             number of stored entries, 0..RSP_DEPTH
module sram_rsp_fifo
  import sram1rw32x50_ctrl_pkg::*;
#(
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RSP_DEPTH = 4,
  parameter int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);

  logic [DATA_W-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/sram1rw32x50_ctrl.sv
// sram1rw32x50_ctrl: request/response front end for a 1RW SRAM macro.
// Ports:
//   CE, RSTB                      clock (shared with macro), async active-low reset
//   req_valid/req_ready           request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready           read-data handshake; rsp_rdata in request order
//   init_done                     high once the post-reset zero-fill has finished
//   A, CSB, WEB, OEB, I           macro pins, all driven straight from flops
//   O                             macro read data, valid the cycle after a read edge
//
// state | meaning
// ------+----------------------------------------------------------------
// INIT  | zero-fill sweep, one write per cycle to A=0..DEPTH-1; requests blocked
// RUN   | normal operation, one request per cycle under response credit
module sram1rw32x50_ctrl
  import sram1rw32x50_ctrl_pkg::*;
#(
  parameter int DEPTH     = SRAM_DEPTH,
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RSP_DEPTH = 4,
  parameter int INIT_EN   = 1
) (
  input  logic              CE,
  input  logic              RSTB,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] A,
  output logic              CSB,
  output logic              WEB,
  output logic              OEB,
  output logic [DATA_W-1:0] I,
  input  logic [DATA_W-1:0] O
);

  localparam int                CNT_W       = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]    CREDIT_LIM  = (CNT_W + 1)'(RSP_DEPTH);
  localparam ctrl_state_e       RESET_STATE = (INIT_EN != 0) ? INIT : RUN;

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic              init_done_q, init_done_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              csb_q, csb_d;
  logic              web_q, web_d;
  logic              oeb_q, oeb_d;
  logic [DATA_W-1:0] i_q, i_d;
  // rd_p1: read strobe on the pins this cycle; rd_p2: macro O holds that read.
  logic              rd_p1_q, rd_p1_d;
  logic              rd_p2_q, rd_p2_d;
  logic [1:0]        rif_q, rif_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              accept;

  // Credits cover both reads still in the macro pipeline and unpopped
  // responses, so the FIFO can never be pushed while full.
  assign credit_used = {{(CNT_W-1){1'b0}}, rif_q} + {1'b0, fifo_count};
  // init_done_q is a flop, so ready is held low for the first cycle after reset.
  assign req_ready   = init_done_q && (credit_used < CREDIT_LIM);
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = (state_q == RUN);
    a_d         = a_q;
    i_d         = i_q;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    oeb_d       = 1'b1;
    rd_p1_d     = 1'b0;
    rd_p2_d     = rd_p1_q;
    unique case (state_q)
      INIT: begin
        csb_d       = 1'b0;
        web_d       = 1'b0;
        a_d         = init_addr_q;
        i_d         = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          state_d     = RUN;
          init_addr_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          csb_d = 1'b0;
          a_d   = req_addr;
          if (req_we) begin
            web_d = 1'b0;
            i_d   = req_wdata;
          end else begin
            oeb_d   = 1'b0;
            rd_p1_d = 1'b1;
          end
        end
      end
      default: state_d = RESET_STATE;
    endcase

    unique case ({rd_p1_d, rd_p2_q})
      2'b10:   rif_d = rif_q + 2'd1;
      2'b01:   rif_d = rif_q - 2'd1;
      default: rif_d = rif_q;
    endcase
  end

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      state_q     <= RESET_STATE;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      a_q         <= '0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      oeb_q       <= 1'b1;
      i_q         <= '0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      rif_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      a_q         <= a_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      i_q         <= i_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      rif_q       <= rif_d;
    end
  end

  sram_rsp_fifo #(
    .DATA_W    (DATA_W),
    .RSP_DEPTH (RSP_DEPTH),
    .CNT_W     (CNT_W)
  ) u_rsp_fifo (
    .clk       (CE),
    .rst_n     (RSTB),
    .push      (rd_p2_q),
    .push_data (O),
    .pop       (rsp_ready),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .count     (fifo_count)
  );

  assign init_done = init_done_q;
  assign A         = a_q;
  assign CSB       = csb_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;
  assign I         = i_q;

endmodule
